// File: rtl/multicycle_controller.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback and
// drives datapath strobes, PC/IR enables and memory handshakes, with sticky trap flags.
module multicycle_controller #(
  parameter int OPCODE_WIDTH = 7,
  parameter int ALUOP_WIDTH  = 2,
  parameter int ENABLE_ITYPE = 1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    imem_ready,
  input  logic                    dmem_ready,
  output logic                    imem_req,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    branch,
  output logic                    regWrite,
  output logic                    memoryToRegister,
  output logic                    ALUSrc,
  output logic                    memoryRead,
  output logic                    memoryWrite,
  output logic [ALUOP_WIDTH-1:0]  ALUOp,
  output logic                    illegal,
  output logic                    bus_error,
  output logic [2:0]              state,
  output logic [CNT_WIDTH-1:0]    instr_retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_R    = 3'd1,
    C_I    = 3'd2,
    C_LD   = 3'd3,
    C_SD   = 3'd4,
    C_BEQ  = 3'd5
  } cls_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_R   = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_I   = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD  = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SD  = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ = OPCODE_WIDTH'(7'b1100011);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            st_q;
  cls_t              cls_q;
  cls_t              dec_cls;
  logic [WAIT_W-1:0] wait_q;

  always_comb begin
    dec_cls = C_NONE;
    if (opcode == OP_R)                            dec_cls = C_R;
    else if (opcode == OP_LD)                      dec_cls = C_LD;
    else if (opcode == OP_SD)                      dec_cls = C_SD;
    else if (opcode == OP_BEQ)                     dec_cls = C_BEQ;
    else if ((ENABLE_ITYPE != 0) && opcode == OP_I) dec_cls = C_I;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q          <= FETCH;
      cls_q         <= C_NONE;
      wait_q        <= '0;
      instr_retired <= '0;
      illegal       <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      case (st_q)
        FETCH: if (imem_ready) st_q <= DECODE;
        DECODE: begin
          cls_q <= dec_cls;
          if (dec_cls == C_NONE) begin
            illegal <= 1'b1;
            st_q    <= TRAP;
          end else begin
            st_q <= EXEC;
          end
        end
        EXEC: begin
          wait_q <= '0;
          case (cls_q)
            C_R, C_I:   st_q <= WB;
            C_LD, C_SD: st_q <= MEM;
            C_BEQ: begin
              st_q          <= FETCH;
              instr_retired <= instr_retired + CNT_WIDTH'(1);
            end
            default:    st_q <= FETCH;
          endcase
        end
        MEM: begin
          // a completing access in the last allowed cycle beats the timeout
          if (dmem_ready) begin
            if (cls_q == C_LD) begin
              st_q <= WB;
            end else begin
              st_q          <= FETCH;
              instr_retired <= instr_retired + CNT_WIDTH'(1);
            end
          end else if (wait_q == WAIT_LAST) begin
            bus_error <= 1'b1;
            st_q      <= TRAP;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        WB: begin
          st_q          <= FETCH;
          instr_retired <= instr_retired + CNT_WIDTH'(1);
        end
        TRAP:    st_q <= TRAP;
        default: st_q <= FETCH;
      endcase
    end
  end

  // strobes come from registered state/class; reset forces them low in the same cycle
  always_comb begin
    imem_req         = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    branch           = 1'b0;
    regWrite         = 1'b0;
    memoryToRegister = 1'b0;
    ALUSrc           = 1'b0;
    memoryRead       = 1'b0;
    memoryWrite      = 1'b0;
    ALUOp            = '0;
    if (!reset) begin
      case (st_q)
        FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
          pc_write = imem_ready;
        end
        EXEC: begin
          case (cls_q)
            C_R: ALUOp = ALUOP_WIDTH'(2'b10);
            C_I: begin
              ALUSrc = 1'b1;
              ALUOp  = ALUOP_WIDTH'(2'b11);
            end
            C_LD, C_SD: ALUSrc = 1'b1;
            C_BEQ: begin
              branch = 1'b1;
              ALUOp  = ALUOP_WIDTH'(2'b01);
            end
            default: ;
          endcase
        end
        MEM: begin
          memoryRead  = (cls_q == C_LD);
          memoryWrite = (cls_q == C_SD);
        end
        WB: begin
          regWrite         = 1'b1;
          memoryToRegister = (cls_q == C_LD);
        end
        default: ;
      endcase
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized bench for multicycle_controller; expected per-cycle strobes
// come from an instruction-level model (class, fetch wait, memory wait).
module tb_multicycle_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, imem_ready, dmem_ready;
  logic [6:0]  opcode;
  logic        imem_req, ir_write, pc_write, branch, regWrite, memoryToRegister;
  logic        ALUSrc, memoryRead, memoryWrite, illegal, bus_error;
  logic [1:0]  ALUOp;
  logic [2:0]  state;
  logic [31:0] instr_retired;

  logic        a_reset, a_ready;
  logic [6:0]  a_opcode;
  logic        a_imem_req, a_ir_write, a_pc_write, a_branch, a_regWrite, a_m2r;
  logic        a_ALUSrc, a_memoryRead, a_memoryWrite, a_illegal, a_bus_error;
  logic [1:0]  a_ALUOp;
  logic [2:0]  a_state;
  logic [3:0]  a_retired;

  multicycle_controller dut (
    .clock(clock), .reset(reset), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .regWrite(regWrite),
    .memoryToRegister(memoryToRegister), .ALUSrc(ALUSrc), .memoryRead(memoryRead),
    .memoryWrite(memoryWrite), .ALUOp(ALUOp), .illegal(illegal), .bus_error(bus_error),
    .state(state), .instr_retired(instr_retired)
  );

  multicycle_controller #(.ENABLE_ITYPE(0), .CNT_WIDTH(4)) aux (
    .clock(clock), .reset(a_reset), .opcode(a_opcode), .imem_ready(a_ready),
    .dmem_ready(a_ready), .imem_req(a_imem_req), .ir_write(a_ir_write),
    .pc_write(a_pc_write), .branch(a_branch), .regWrite(a_regWrite),
    .memoryToRegister(a_m2r), .ALUSrc(a_ALUSrc), .memoryRead(a_memoryRead),
    .memoryWrite(a_memoryWrite), .ALUOp(a_ALUOp), .illegal(a_illegal),
    .bus_error(a_bus_error), .state(a_state), .instr_retired(a_retired)
  );

  typedef struct packed {
    logic imem_req, ir_write, pc_write, branch, regw, m2r, alusrc, mrd, mwr;
    logic [1:0] aluop;
    logic [2:0] st;
  } sig_t;

  localparam int R = 0, I = 1, LD = 2, SD = 3, BEQ = 4;

  int errors  = 0;
  int checks  = 0;
  int exp_ret = 0;

  function automatic logic [6:0] op_of(input int c);
    case (c)
      R:       return 7'b0110011;
      I:       return 7'b0010011;
      LD:      return 7'b0000011;
      SD:      return 7'b0100011;
      default: return 7'b1100011;
    endcase
  endfunction

  function automatic logic [6:0] noise();
    return 7'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic sig_t main_sig();
    return {imem_req, ir_write, pc_write, branch, regWrite, memoryToRegister,
            ALUSrc, memoryRead, memoryWrite, ALUOp, state};
  endfunction

  function automatic sig_t aux_sig();
    return {a_imem_req, a_ir_write, a_pc_write, a_branch, a_regWrite, a_m2r,
            a_ALUSrc, a_memoryRead, a_memoryWrite, a_ALUOp, a_state};
  endfunction

  // phase: 0 fetch, 1 decode, 2 execute, 3 memory, 4 writeback, 5 trap
  function automatic sig_t exp_sig(input int phase, input int cls, input logic last);
    sig_t e;
    e    = '0;
    e.st = 3'(phase);
    case (phase)
      0: begin
        e.imem_req = 1'b1;
        e.ir_write = last;
        e.pc_write = last;
      end
      2: begin
        e.alusrc = (cls == I || cls == LD || cls == SD);
        e.branch = (cls == BEQ);
        e.aluop  = (cls == R) ? 2'b10 : (cls == I) ? 2'b11 : (cls == BEQ) ? 2'b01 : 2'b00;
      end
      3: begin
        e.mrd = (cls == LD);
        e.mwr = (cls == SD);
      end
      4: begin
        e.regw = 1'b1;
        e.m2r  = (cls == LD);
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ir, input logic dr, input logic [6:0] op);
    @(negedge clock);
    imem_ready = ir;
    dmem_ready = dr;
    opcode     = op;
    #1;
  endtask

  task automatic run_front(input int cls, input int iw, input string tag);
    for (int k = 0; k <= iw; k++) begin
      cyc(k == iw, rb(), noise());
      if (k == 0) chk({tag, " retired"}, instr_retired, 32'(exp_ret));
      chk({tag, " fetch"}, 32'(main_sig()), 32'(exp_sig(0, cls, k == iw)));
    end
    cyc(rb(), rb(), op_of(cls));
    chk({tag, " decode"}, 32'(main_sig()), 32'(exp_sig(1, cls, 1'b0)));
    cyc(rb(), rb(), noise());
    chk({tag, " exec"}, 32'(main_sig()), 32'(exp_sig(2, cls, 1'b0)));
  endtask

  task automatic run_instr(input int cls, input int iw, input int dw, input string tag);
    run_front(cls, iw, tag);
    if (cls == LD || cls == SD) begin
      for (int k = 0; k <= dw; k++) begin
        cyc(rb(), k == dw, noise());
        chk({tag, " mem"}, 32'(main_sig()), 32'(exp_sig(3, cls, 1'b0)));
      end
    end
    if (cls == R || cls == I || cls == LD) begin
      cyc(rb(), rb(), noise());
      chk({tag, " wb"}, 32'(main_sig()), 32'(exp_sig(4, cls, 1'b0)));
    end
    exp_ret++;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    cyc(1'b1, 1'b1, noise());
    chk({tag, " strobes low in reset"}, 32'(main_sig() & ~14'h7), 32'h0);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    exp_ret = 0;
    cyc(1'b0, 1'b0, noise());
    chk({tag, " state after"}, 32'(main_sig()), 32'(exp_sig(0, R, 1'b0)));
    chk({tag, " illegal clr"}, 32'(illegal), 32'h0);
    chk({tag, " bus_error clr"}, 32'(bus_error), 32'h0);
    chk({tag, " retired clr"}, instr_retired, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = op_of(R);
    a_reset = 1'b1; a_ready = 1'b1; a_opcode = op_of(BEQ);
    repeat (2) @(negedge clock);
    #1;
    chk("reset outputs", 32'(main_sig()), 32'h0);
    chk("reset illegal", 32'(illegal), 32'h0);
    chk("reset bus_error", 32'(bus_error), 32'h0);
    chk("reset retired", instr_retired, 32'h0);
    imem_ready = 1'b0;
    reset      = 1'b0;

    run_instr(R,   0, 0,  "rtype");
    run_instr(LD,  0, 3,  "ld_wait3");
    run_instr(BEQ, 0, 0,  "beq");
    run_instr(SD,  0, 0,  "sd");
    run_instr(I,   1, 0,  "itype");
    run_instr(SD,  0, 15, "sd_ready_on_16");
    chk("no bus_error at boundary", 32'(bus_error), 32'h0);

    repeat (25) run_instr($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 14), "rand");
    cyc(1'b0, 1'b0, noise());
    chk("rand retired", instr_retired, 32'(exp_ret));
    chk("rand flags", 32'({illegal, bus_error}), 32'h0);

    // data memory never answers a store
    run_front(SD, 0, "timeout");
    for (int k = 0; k < 16; k++) begin
      cyc(rb(), 1'b0, noise());
      chk("timeout mem", 32'(main_sig()), 32'(exp_sig(3, SD, 1'b0)));
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b1, noise());
      chk("timeout trap", 32'(main_sig()), 32'(exp_sig(5, SD, 1'b0)));
      chk("timeout bus_error", 32'(bus_error), 32'h1);
      chk("timeout retired", instr_retired, 32'(exp_ret));
    end
    do_reset("after_timeout");

    // reset lands while a load is waiting in MEM
    run_front(LD, 0, "mid_mem");
    for (int k = 0; k < 2; k++) begin
      cyc(rb(), 1'b0, noise());
      chk("mid_mem mem", 32'(main_sig()), 32'(exp_sig(3, LD, 1'b0)));
    end
    do_reset("mid_mem");
    run_instr(R, 0, 0, "resume");
    cyc(1'b0, 1'b0, noise());
    chk("resume retired", instr_retired, 32'(exp_ret));

    // unknown opcode traps and holds
    cyc(1'b1, 1'b0, noise());
    chk("ill fetch", 32'(main_sig()), 32'(exp_sig(0, R, 1'b1)));
    cyc(1'b0, 1'b0, 7'h7f);
    chk("ill decode", 32'(main_sig()), 32'(exp_sig(1, R, 1'b0)));
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, rb(), noise());
      chk("ill trap", 32'(main_sig()), 32'(exp_sig(5, R, 1'b0)));
      chk("ill flag", 32'(illegal), 32'h1);
    end
    do_reset("after_illegal");

    // narrow counter: 16 back-to-back BEQs with ready tied high
    a_reset = 1'b0;
    repeat (45) @(posedge clock);
    #1;
    chk("wrap retired 15", 32'(a_retired), 32'd15);
    chk("wrap state", 32'(a_state), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("wrap retired 0", 32'(a_retired), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("aux beq exec", 32'(aux_sig()), 32'(exp_sig(2, BEQ, 1'b0)));
    a_opcode = op_of(I);
    repeat (3) @(posedge clock);
    #1;
    chk("aux itype trap", 32'(a_state), 32'd5);
    chk("aux illegal", 32'(a_illegal), 32'h1);
    repeat (20) @(posedge clock);
    #1;
    chk("aux trap held", 32'(aux_sig()), 32'(exp_sig(5, I, 1'b0)));
    chk("aux retired", 32'(a_retired), 32'd1);
    chk("aux bus_error", 32'(a_bus_error), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
